// File: rtl/sram_sp_arbiter_if.sv
// Bus bundle between the arbiter, its write/read/response clients and the SRAM macro pins.
// The slave modport is the arbiter's view; master is the clients' plus macro side.
interface sram_sp_arbiter_if #(
  parameter int DATA_W = 80,
  parameter int ADDR_W = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              init_done;
  logic              sram_ceb;
  logic              sram_web;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_d;
  logic [DATA_W-1:0] sram_q;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, resp_ready, sram_q,
    output wr_ready, rd_ready, resp_valid, resp_data, init_done,
           sram_ceb, sram_web, sram_a, sram_d
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, resp_ready, sram_q,
    input  wr_ready, rd_ready, resp_valid, resp_data, init_done,
           sram_ceb, sram_web, sram_a, sram_d
  );
endinterface

// File: rtl/sram_sp_arbiter.sv
// Single-port SRAM sequencer: zero-fills the macro after reset, then round-robins one
// writer and one reader onto the port, returning read data through a 2-entry FIFO.
module sram_sp_arbiter #(
  parameter int DATA_W  = 80,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int INIT_EN = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  sram_sp_arbiter_if.slave  bus
);
  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam state_t            RST_STATE = (INIT_EN != 0) ? S_INIT : S_RUN;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_init_cnt;
  logic              r_init_done;
  logic              r_infl;
  logic              r_prio_rd;
  logic [1:0]        r_occ;
  logic [DATA_W-1:0] r_buf0;
  logic [DATA_W-1:0] r_buf1;

  logic              w_run;
  logic              w_pop;
  logic              w_push;
  logic [2:0]        w_pending;
  logic              w_rd_ok;
  logic              w_wr_elig;
  logic              w_rd_elig;
  logic              w_contend;
  logic              w_gnt_wr;
  logic              w_gnt_rd;
  logic              w_ceb;
  logic              w_web;
  logic [ADDR_W-1:0] w_a;
  logic [DATA_W-1:0] w_d;

  // Credit check counts the read already in flight and the pop happening this cycle.
  assign w_run     = (r_state == S_RUN);
  assign w_pop     = (r_occ != 2'd0) && bus.resp_ready;
  assign w_push    = r_infl;
  assign w_pending = {1'b0, r_occ} + {2'b00, r_infl};
  assign w_rd_ok   = w_pending < (3'd2 + {2'b00, w_pop});

  assign w_wr_elig = w_run && bus.wr_valid;
  assign w_rd_elig = w_run && bus.rd_valid && w_rd_ok;
  assign w_contend = w_wr_elig && w_rd_elig;
  assign w_gnt_wr  = w_wr_elig && !(w_contend && r_prio_rd);
  assign w_gnt_rd  = w_rd_elig && !(w_contend && !r_prio_rd);

  always_comb begin
    w_state_nxt = r_state;
    w_ceb       = 1'b1;
    w_web       = 1'b1;
    w_a         = '0;
    w_d         = '0;
    case (r_state)
      S_INIT: begin
        w_ceb = 1'b0;
        w_web = 1'b0;
        w_a   = r_init_cnt;
        if (r_init_cnt == LAST_ADDR) w_state_nxt = S_RUN;
      end
      default: begin
        if (w_gnt_wr) begin
          w_ceb = 1'b0;
          w_web = 1'b0;
          w_a   = bus.wr_addr;
          w_d   = bus.wr_data;
        end else if (w_gnt_rd) begin
          w_ceb = 1'b0;
          w_a   = bus.rd_addr;
        end
      end
    endcase
  end

  // Macro pins and readies are forced idle while reset is asserted, without waiting for a clock.
  assign bus.sram_ceb   = w_ceb | ~reset_n;
  assign bus.sram_web   = w_web | ~reset_n;
  assign bus.sram_a     = reset_n ? w_a : '0;
  assign bus.sram_d     = reset_n ? w_d : '0;
  assign bus.wr_ready   = reset_n && w_gnt_wr;
  assign bus.rd_ready   = reset_n && w_gnt_rd;
  assign bus.resp_valid = (r_occ != 2'd0);
  assign bus.resp_data  = r_buf0;
  assign bus.init_done  = r_init_done;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RST_STATE;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
      r_infl      <= 1'b0;
      r_prio_rd   <= 1'b0;
      r_occ       <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) r_init_cnt <= r_init_cnt + ADDR_W'(1);
      if (w_state_nxt == S_RUN) r_init_done <= 1'b1;
      r_infl <= w_gnt_rd;
      // Only a contended cycle moves the pointer: the loser gets priority next time.
      if (w_contend) r_prio_rd <= w_gnt_wr;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Response storage: r_buf0 is always the head; contents are don't-care when empty.
  always_ff @(posedge clock) begin
    if (w_push && w_pop) begin
      if (r_occ == 2'd2) begin
        r_buf0 <= r_buf1;
        r_buf1 <= bus.sram_q;
      end else begin
        r_buf0 <= bus.sram_q;
      end
    end else if (w_pop) begin
      r_buf0 <= r_buf1;
    end else if (w_push) begin
      if (r_occ == 2'd0) r_buf0 <= bus.sram_q;
      else               r_buf1 <= bus.sram_q;
    end
  end
endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Directed bench for sram_sp_arbiter with a behavioural 256x80 single-port macro model.
module tb_sram_sp_arbiter;
  localparam int DATA_W = 80;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  logic [DATA_W-1:0] mem [DEPTH];

  sram_sp_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sram_sp_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .INIT_EN(1)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Macro model: write on CEB=0/WEB=0, Q valid the cycle after a read, garbage otherwise.
  always @(posedge clock) begin
    if (!bus.sram_ceb && !bus.sram_web) mem[bus.sram_a] <= bus.sram_d;
    if (!bus.sram_ceb && bus.sram_web) bus.sram_q <= mem[bus.sram_a];
    else                               bus.sram_q <= {DATA_W{1'bx}};
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          output bit ok);
    bus.wr_addr  = addr;
    bus.wr_data  = data;
    bus.wr_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      if (bus.wr_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] data,
                         output int wait_cyc, output int lat, output bit ok);
    bus.rd_addr  = addr;
    bus.rd_valid = 1'b1;
    ok       = 1'b0;
    wait_cyc = -1;
    lat      = -1;
    data     = {DATA_W{1'bx}};
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      if (bus.rd_ready === 1'b1) begin
        wait_cyc = n;
        break;
      end
      tick();
    end
    tick();
    bus.rd_valid = 1'b0;
    if (wait_cyc >= 0) begin
      for (int n = 1; n <= 10; n++) begin
        @(negedge clock);
        if (bus.resp_valid === 1'b1) begin
          lat  = n;
          data = bus.resp_data;
          ok   = 1'b1;
          break;
        end
        tick();
      end
      tick();
    end
  endtask

  task automatic test_reset;
    bus.wr_valid   = 1'b1;
    bus.rd_valid   = 1'b1;
    bus.resp_ready = 1'b1;
    bus.wr_addr    = 8'h33;
    bus.wr_data    = {DATA_W{1'b1}};
    bus.rd_addr    = 8'h44;
    reset_n        = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    checks++; if (bus.sram_ceb !== 1'b1) begin errors++; $display("FAIL reset_ceb: got %b want 1", bus.sram_ceb); end
    checks++; if (bus.sram_web !== 1'b1) begin errors++; $display("FAIL reset_web: got %b want 1", bus.sram_web); end
    checks++; if (bus.sram_a !== '0) begin errors++; $display("FAIL reset_a: got %h want 0", bus.sram_a); end
    checks++; if (bus.sram_d !== '0) begin errors++; $display("FAIL reset_d: got %h want 0", bus.sram_d); end
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b want 0", bus.wr_ready); end
    checks++; if (bus.rd_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready: got %b want 0", bus.rd_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", bus.init_done); end
  endtask

  task automatic test_init;
    logic [DATA_W-1:0] rdata;
    int                wc;
    int                lat;
    bit                ok;
    logic [ADDR_W-1:0] addrs [3];
    addrs[0] = 8'h00;
    addrs[1] = 8'h80;
    addrs[2] = 8'hFF;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      checks++;
      if (bus.sram_ceb !== 1'b0 || bus.sram_web !== 1'b0 || bus.sram_a !== i[ADDR_W-1:0] ||
          bus.sram_d !== '0 || bus.wr_ready !== 1'b0 || bus.rd_ready !== 1'b0 || bus.init_done !== 1'b0) begin
        errors++;
        $display("FAIL init_cycle%0d: ceb=%b web=%b a=%h d=%h wr_rdy=%b rd_rdy=%b done=%b want 0 0 %h 0 0 0 0",
                 i + 1, bus.sram_ceb, bus.sram_web, bus.sram_a, bus.sram_d, bus.wr_ready, bus.rd_ready,
                 bus.init_done, i[ADDR_W-1:0]);
      end
      if (i == DEPTH - 1) begin
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b0;
      end
      tick();
    end
    @(negedge clock);
    checks++; if (bus.init_done !== 1'b1) begin errors++; $display("FAIL init_done_257: got %b want 1", bus.init_done); end
    checks++; if (bus.sram_ceb !== 1'b1) begin errors++; $display("FAIL idle_ceb_257: got %b want 1", bus.sram_ceb); end
    tick();
    for (int k = 0; k < 3; k++) begin
      do_read(addrs[k], rdata, wc, lat, ok);
      checks++;
      if (!ok || rdata !== '0) begin
        errors++;
        $display("FAIL zero_read_%h: ok=%0d data=%h want ok=1 data=0", addrs[k], ok, rdata);
      end
    end
  endtask

  task automatic test_write_read;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    int                wc;
    int                lat;
    bit                ok;
    wdata = 80'h00AB_1234_5678_9ABC_DECD;
    bus.resp_ready = 1'b1;
    do_write(8'h12, wdata, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_accept: got ok=%0d want 1", ok); end
    do_read(8'h12, rdata, wc, lat, ok);
    checks++; if (wc !== 0) begin errors++; $display("FAIL rd_accept_wait: got %0d want 0", wc); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d want 2", lat); end
    checks++; if (rdata !== wdata) begin errors++; $display("FAIL rd_data: got %h want %h", rdata, wdata); end
  endtask

  task automatic test_round_robin;
    bit exp_w;
    bus.resp_ready = 1'b1;
    bus.wr_addr    = 8'h30;
    bus.wr_data    = 80'h1;
    bus.rd_addr    = 8'h12;
    bus.wr_valid   = 1'b1;
    bus.rd_valid   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      exp_w = (i % 2 == 0);
      checks++;
      if (bus.wr_ready !== exp_w || bus.rd_ready !== !exp_w) begin
        errors++;
        $display("FAIL rr_grant%0d: wr_ready=%b rd_ready=%b want %b %b",
                 i, bus.wr_ready, bus.rd_ready, exp_w, !exp_w);
      end
      tick();
      bus.wr_addr = bus.wr_addr + 8'd1;
    end
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_backpressure;
    logic [DATA_W-1:0] da;
    logic [DATA_W-1:0] db;
    bit                ok;
    int                acc;
    da = 80'hAAAA_0000_1111_2222_3333;
    db = 80'hBBBB_4444_5555_6666_7777;
    do_write(8'h40, da, ok);
    do_write(8'h41, db, ok);
    bus.resp_ready = 1'b0;
    bus.rd_addr    = 8'h40;
    bus.rd_valid   = 1'b1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (bus.rd_ready === 1'b1) acc++;
      if (i >= 2) begin
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== da) begin
          errors++;
          $display("FAIL bp_hold%0d: valid=%b data=%h want 1 %h", i, bus.resp_valid, bus.resp_data, da);
        end
      end
      tick();
      if (acc == 1) bus.rd_addr = 8'h41;
    end
    checks++; if (acc !== 2) begin errors++; $display("FAIL bp_accepts: got %0d want 2", acc); end
    @(negedge clock);
    checks++; if (bus.rd_ready !== 1'b0) begin errors++; $display("FAIL bp_rd_ready: got %b want 0", bus.rd_ready); end
    bus.rd_valid   = 1'b0;
    bus.resp_ready = 1'b1;
    tick();
    @(negedge clock);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== db) begin
      errors++;
      $display("FAIL bp_second: valid=%b data=%h want 1 %h", bus.resp_valid, bus.resp_data, db);
    end
    tick();
    @(negedge clock);
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", bus.resp_valid); end
    bus.rd_addr  = 8'h40;
    bus.rd_valid = 1'b1;
    #1;
    checks++; if (bus.rd_ready !== 1'b1) begin errors++; $display("FAIL bp_resume: got %b want 1", bus.rd_ready); end
    tick();
    bus.rd_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_init;
    int cyc;
    bit seq_bad;
    @(negedge clock);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (100) tick();
    @(negedge clock);
    checks++;
    if (bus.sram_ceb !== 1'b0 || bus.sram_a !== 8'd100) begin
      errors++;
      $display("FAIL mid_init_pos: ceb=%b a=%0d want 0 100", bus.sram_ceb, bus.sram_a);
    end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.sram_ceb !== 1'b1) begin errors++; $display("FAIL mid_init_ceb: got %b want 1", bus.sram_ceb); end
    tick();
    tick();
    reset_n = 1'b1;
    cyc     = -1;
    seq_bad = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (bus.init_done === 1'b1) begin
        cyc = i;
        break;
      end
      if (bus.sram_ceb !== 1'b0 || bus.sram_a !== i[ADDR_W-1:0]) seq_bad = 1'b1;
      tick();
    end
    checks++; if (cyc !== DEPTH) begin errors++; $display("FAIL reinit_len: got %0d want %0d", cyc, DEPTH); end
    checks++; if (seq_bad) begin errors++; $display("FAIL reinit_seq: got bad=1 want 0"); end
    tick();
  endtask

  task automatic test_reset_mid_read;
    bit stale;
    bus.resp_ready = 1'b0;
    bus.rd_addr    = 8'h12;
    bus.rd_valid   = 1'b1;
    @(negedge clock);
    checks++; if (bus.rd_ready !== 1'b1) begin errors++; $display("FAIL mr_acc1: got %b want 1", bus.rd_ready); end
    tick();
    @(negedge clock);
    checks++; if (bus.rd_ready !== 1'b1) begin errors++; $display("FAIL mr_acc2: got %b want 1", bus.rd_ready); end
    tick();
    bus.rd_valid = 1'b0;
    @(negedge clock);
    checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL mr_buffered: got %b want 1", bus.resp_valid); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL mr_flush: got %b want 0", bus.resp_valid); end
    bus.resp_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    stale   = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (bus.resp_valid !== 1'b0) stale = 1'b1;
      tick();
    end
    checks++; if (stale) begin errors++; $display("FAIL mr_stale: got stale=1 want 0"); end
    checks++; if (bus.init_done !== 1'b1) begin errors++; $display("FAIL mr_init_done: got %b want 1", bus.init_done); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = {10{8'hA5}};
    bus.wr_valid   = 1'b0;
    bus.rd_valid   = 1'b0;
    bus.resp_ready = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.rd_addr    = '0;
    test_reset();
    test_init();
    test_write_read();
    test_round_robin();
    test_backpressure();
    test_reset_mid_init();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
